alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- ID→EX pipeline stage that produces the ALU's control and operand interface: SrcA, SrcB and the 4-bit Operation code.
- Decodes the RV32I subset the ALU supports.
- Selects the operands, then registers them into an EX slot with a valid/ready handshake, flush and an issue counter.
- Sits between instruction decode/register file and the ALU.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- OPCODE_LENGTH, 4, width of the ALU Operation code.
- REG_ADDR_WIDTH, 5, width of a register index.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds an instruction.
- id_ready  out  1  stage accepts the instruction this cycle.
- id_instr  in  32  raw instruction.
- id_rs1_data  in  DATA_WIDTH  register file read port 1.
- id_rs2_data  in  DATA_WIDTH  register file read port 2.
- id_imm  in  DATA_WIDTH  sign-extended immediate from the immediate generator.
- flush  in  1  kill the EX slot and any instruction accepted this cycle.
- ex_ready  in  1  EX consumes the slot this cycle.
- ex_valid  out  1  EX slot occupied.
- ex_SrcA  out  DATA_WIDTH  ALU operand A.
- ex_SrcB  out  DATA_WIDTH  ALU operand B.
- ex_Operation  out  OPCODE_LENGTH  ALU operation code.
- ex_rd  out  REG_ADDR_WIDTH  destination register.
- ex_reg_write  out  1  result is written back.
- ex_branch  out  1  instruction is BEQ; EX uses ALUResult[0] as taken.
- ex_illegal  out  1  instruction not in the supported subset.
- issue_count  out  32  number of instructions loaded into EX.

Behaviour:
- Reset: all outputs and registers are 0.
  - reset_n is asynchronous; asserting it mid-transfer discards the slot.
  - Deassertion is sampled on clk.
- Operation encoding is fixed: AND=0000, OR=0001, ADD=0010, XOR=0100, EQUAL=1000.
- Decode. Opcode is instr[6:0], funct3 is instr[14:12], funct7 is instr[31:25].
  - R-type (0110011), funct7=0000000:
    - f3=000 → ADD; f3=100 → XOR; f3=110 → OR; f3=111 → AND.
    - SrcA=rs1, SrcB=rs2, reg_write=1.
  - I-type ALU (0010011), same f3 mapping:
    - SrcA=rs1, SrcB=imm, reg_write=1.
  - LW (0000011, f3=010) and SW (0100011, f3=010):
    - ADD, SrcA=rs1, SrcB=imm.
    - reg_write is 1 for LW, 0 for SW.
  - BEQ (1100011, f3=000):
    - EQUAL, SrcA=rs1, SrcB=rs2, branch=1, reg_write=0.
  - Anything else, including R-type with other funct7:
    - illegal=1, Operation=0000, SrcA=SrcB=0, reg_write=0, branch=0.
  - ex_rd = instr[11:7] for all instructions; it is forced to 0 when reg_write=0.
- Handshake:
  - id_ready = !ex_valid || ex_ready. This is combinational and independent of flush.
  - Load happens when id_valid && id_ready.
  - Latency is one cycle: an instruction accepted at edge N is on the ex_* outputs after edge N.
- Slot update priority, evaluated each edge:
  - flush → ex_valid=0; the accepted instruction is dropped and data is don't-care.
  - else load → ex_valid=1 and all ex_* fields are written.
  - else ex_ready && ex_valid → ex_valid=0.
  - else hold: every ex_* output is stable while ex_valid && !ex_ready.
- Simultaneous ex_ready and load: the slot is replaced back-to-back with no bubble, giving full throughput.
- Illegal instructions occupy the slot with ex_valid=1 and ex_illegal=1, so EX can trap.
- issue_count increments on each non-flushed load, including illegal instructions, and wraps from 0xFFFFFFFF to 0.
- When ex_valid=0, the ex_* data fields are don't-care; implementations keep the last values.

Decomposition:
- Shared package alu_pkg holds:
  - alu_op_t enum (AND, OR, ADD, XOR, EQUAL with the codes above);
  - RV opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH);
  - funct3 constants.
- Sub-module alu_op_decode: purely combinational instr → {Operation, use_imm, reg_write, branch, illegal}.
- The top holds the operand muxes, the EX slot register and the counter.

Test Plan:
- Reset: reset_n=0 mid-stream → all outputs 0 immediately, without a clock edge; issue_count=0.
- ADD x3,x1,x2 with rs1=5, rs2=7, ex_ready=1 → next cycle ex_valid=1, Operation=0010, SrcA=5, SrcB=7, rd=3, reg_write=1.
- Decode sweep:
  - XORI with imm=0xFFFFFFFF → Operation=0100, SrcB=0xFFFFFFFF.
  - BEQ with rs1=rs2=9 → Operation=1000, branch=1, rd=0.
  - SW → ADD, reg_write=0.
  - funct7=0100000 → illegal=1, Operation=0000.
- Backpressure: ex_ready=0 for 3 cycles with id_valid=1 → id_ready=0, ex_* held stable. ex_ready=1 → next instruction loaded the same edge, no bubble.
- Flush: flush=1 on the same edge as a load → ex_valid=0 next cycle, issue_count unchanged, id_ready was 1.
- Counter wrap: preload via 2^32-1 loads (or a force) → next load gives issue_count=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, RV32I opcode/funct constants,
// decoder result record and funct3 helpers.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_XOR   = 4'b0100,
    ALU_EQUAL = 4'b1000
  } alu_op_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;

  // Decoded control for one instruction.
  typedef struct packed {
    alu_op_t op;
    logic    use_imm;
    logic    reg_write;
    logic    branch;
    logic    illegal;
  } dec_t;

  // funct3 values shared by the R-type and I-type ALU groups.
  function automatic logic f3_is_alu(input logic [2:0] f3);
    return (f3 == F3_ADD) || (f3 == F3_XOR) || (f3 == F3_OR) || (f3 == F3_AND);
  endfunction

  function automatic alu_op_t f3_to_op(input logic [2:0] f3);
    case (f3)
      F3_ADD:  return ALU_ADD;
      F3_XOR:  return ALU_XOR;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of the supported RV32I subset into ALU controls.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_instr_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  // Register indices and immediate bits are not needed to pick the operation.
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  // Map opcode/funct fields to the ALU operation and operand/writeback controls.
  always_comb begin
    // NOTE: every field gets a default up front so no path leaves one unassigned (no latch).
    dec = '0;
    dec.op = ALU_AND;
    case (opcode)
      OP_R: begin
        if (funct7 == F7_BASE && f3_is_alu(funct3)) begin
          dec.op        = f3_to_op(funct3);
          dec.reg_write = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_I: begin
        if (f3_is_alu(funct3)) begin
          dec.op        = f3_to_op(funct3);
          dec.use_imm   = 1'b1;
          dec.reg_write = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_LOAD, OP_STORE: begin
        if (funct3 == F3_WORD) begin
          dec.op        = ALU_ADD;
          dec.use_imm   = 1'b1;
          dec.reg_write = (opcode == OP_LOAD);
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_BRANCH: begin
        if (funct3 == F3_BEQ) begin
          dec.op     = ALU_EQUAL;
          dec.branch = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decodes the instruction, selects ALU operands and
// registers them into a single EX slot behind a valid/ready handshake.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int OPCODE_LENGTH  = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      id_valid,
  output logic                      id_ready,
  input  logic [31:0]               id_instr,
  input  logic [DATA_WIDTH-1:0]     id_rs1_data,
  input  logic [DATA_WIDTH-1:0]     id_rs2_data,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic                      flush,
  input  logic                      ex_ready,
  output logic                      ex_valid,
  output logic [DATA_WIDTH-1:0]     ex_SrcA,
  output logic [DATA_WIDTH-1:0]     ex_SrcB,
  output logic [OPCODE_LENGTH-1:0]  ex_Operation,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      ex_reg_write,
  output logic                      ex_branch,
  output logic                      ex_illegal,
  output logic [31:0]               issue_count
);

  dec_t                      dec;
  logic [DATA_WIDTH-1:0]     src_a;
  logic [DATA_WIDTH-1:0]     src_b;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic                      load;

  alu_op_decode u_decode (
    .instr (id_instr),
    .dec   (dec)
  );

  // Slot can take a new instruction when empty or being drained this cycle.
  assign id_ready = !ex_valid || ex_ready;
  assign load     = id_valid && id_ready;

  // Operand muxes; illegal instructions present zero operands, rd is zero without writeback.
  always_comb begin
    src_a = id_rs1_data;
    src_b = dec.use_imm ? id_imm : id_rs2_data;
    rd    = dec.reg_write ? id_instr[7 +: REG_ADDR_WIDTH] : '0;
    if (dec.illegal) begin
      src_a = '0;
      src_b = '0;
    end
  end

  // EX slot: flush beats load beats drain; otherwise every field holds.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the data fields are reset too, because all outputs must read 0 during reset.
    if (!reset_n) begin
      ex_valid     <= 1'b0;
      ex_SrcA      <= '0;
      ex_SrcB      <= '0;
      ex_Operation <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_branch    <= 1'b0;
      ex_illegal   <= 1'b0;
    end else if (flush) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      ex_valid <= 1'b0;
    end else if (load) begin
      ex_valid     <= 1'b1;
      ex_SrcA      <= src_a;
      ex_SrcB      <= src_b;
      ex_Operation <= OPCODE_LENGTH'(dec.op);
      ex_rd        <= rd;
      ex_reg_write <= dec.reg_write;
      ex_branch    <= dec.branch;
      ex_illegal   <= dec.illegal;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  // Issue counter: counts every load that survives flush, wrapping naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue_count <= '0;
    end else if (load && !flush) begin
      issue_count <= issue_count + 32'd1;
    end
  end

endmodule
